ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter SYNC_STAGES, 2: synchroniser depth for keyboard_clk and data; legal values are 2 or more.
REQ-002 Parameter FILTER_LEN, 4: consecutive equal samples needed before the filtered keyboard_clk changes; legal values are 1 or more.
REQ-003 Parameter TIMEOUT_CYCLES, 2000: maximum sys_clk cycles between falling edges inside a frame.
REQ-004 sys_clk  in  1  system clock; the single clock for all logic.
REQ-005 rst_n  in  1  reset; synchronous to sys_clk and active-low.
REQ-006 keyboard_clk  in  1  asynchronous PS/2 clock from the keyboard; idle high.
REQ-007 data  in  1  asynchronous PS/2 data line; idle high.
REQ-008 rx_data  out  8  last correctly received byte.
REQ-009 rx_valid  out  1  one-cycle pulse when rx_data is updated.
REQ-010 parity_err  out  1  one-cycle pulse when a frame has bad odd parity.
REQ-011 frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-012 busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL pass keyboard_clk and data each through SYNC_STAGES flip-flops, all reset to 1.
REQ-014 The filtered clock SHALL change only after FILTER_LEN consecutive equal synchronised samples; shorter glitches SHALL be ignored.
REQ-015 A falling edge SHALL be detected in the cycle the filtered clock is 0 and its registered previous value is 1; data SHALL be sampled (synchronised) in that same cycle.
REQ-016 The frame SHALL be 11 bits: start bit 0, data[7:0] LSB first, parity, stop bit 1.
REQ-017 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: an edge with data=0 SHALL go to DATA with the bit counter cleared; an edge with data=1 SHALL be ignored with no error.
REQ-019 DATA: each edge SHALL shift the sampled bit into bit 7 of the shift register and shift right; after the 8th bit the FSM SHALL go to PARITY.
REQ-020 PARITY: the sampled bit SHALL be stored and the FSM SHALL go to STOP.
REQ-021 STOP, stop bit 1 with odd parity correct (data bits plus parity bit hold an odd number of 1s): rx_data SHALL load and rx_valid SHALL pulse in cycle N+1, where N is the stop-edge cycle.
REQ-022 STOP, stop bit 1 with parity wrong: parity_err SHALL pulse at N+1 and rx_data SHALL hold its old value.
REQ-023 STOP, stop bit 0: frame_err SHALL pulse at N+1 whatever the parity; parity_err SHALL stay low and rx_data SHALL hold.
REQ-024 Every STOP outcome SHALL return the FSM to IDLE at N+1.
REQ-025 Outside IDLE, a watchdog SHALL count sys_clk cycles and clear on each falling edge.
REQ-026 When the watchdog reaches TIMEOUT_CYCLES, frame_err SHALL pulse, the FSM SHALL return to IDLE, and partial data SHALL be discarded.
REQ-027 If an edge and a timeout occur in the same cycle, the edge SHALL win.
REQ-028 At most one of rx_valid, parity_err and frame_err SHALL be high in any cycle.

Reset
REQ-029 While rst_n=0 at a sys_clk edge: state SHALL be IDLE, rx_data 8'h00, rx_valid, parity_err, frame_err and busy 0, counters and shift register 0, synchroniser and filter registers 1.
REQ-030 Reset mid-frame SHALL discard the frame with no error pulse; the first complete frame after release SHALL be received normally.

Structure
REQ-031 Package ps2_pkg SHALL hold the FSM state enum, FRAME_BITS=11, DATA_BITS=8, and an odd-parity function.
REQ-032 The synchroniser, glitch filter and falling-edge detector SHALL form one sub-module, ps2_sync_filter, instantiated once per line (keyboard_clk and data).

Verification
REQ-033 Frame 0xAA with parity 1 and stop 1 -> rx_valid one pulse, rx_data=8'hAA, no error pulse.
REQ-034 Frame 0xAA with parity 0 -> parity_err one pulse, rx_valid stays 0, rx_data holds its previous value.
REQ-035 Frame 0x1C with correct parity and stop 0 -> frame_err one pulse; a following good 0x1C frame -> rx_valid with rx_data=8'h1C.
REQ-036 keyboard_clk stopped after 5 bits -> frame_err exactly TIMEOUT_CYCLES after the last edge, busy falls, the next 0x55 frame is received.
REQ-037 1-cycle low glitches on keyboard_clk between bits with FILTER_LEN=4 -> no extra bit; 0xAA is still received.
REQ-038 rst_n=0 for 2 cycles mid-frame -> all outputs 0 with no pulse; the next 0xF0 frame -> rx_valid with rx_data=8'hF0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Parity bit value that makes data plus parity hold an odd number of ones.
    function automatic logic odd_parity_bit(input logic [DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Per-line synchroniser, glitch filter and falling-edge detector for PS/2 inputs.
module ps2_sync_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_sync,
    output logic o_filt,
    output logic o_fall_c
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filt;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Filtered level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_filt <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_prev <= r_filt;
            if (w_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sync   = w_sync;
    assign o_filt   = r_filt;
    assign o_fall_c = r_prev & ~r_filt;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, checks odd parity and stop bit,
// and aborts a frame whose keyboard clock stalls for TIMEOUT_CYCLES.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 keyboard_clk,
    input  logic                 data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);
    localparam int unsigned WD_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_DATA   = ST_DATA;
    localparam logic [1:0] S_PARITY = ST_PARITY;
    localparam logic [1:0] S_STOP   = ST_STOP;

    logic w_fall;
    logic w_data;
    logic w_clk_sync;
    logic w_clk_filt;
    logic w_data_filt;
    logic w_data_fall;
    logic w_unused;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_line (
        .i_clk    (sys_clk),
        .i_rst_n  (rst_n),
        .i_line   (keyboard_clk),
        .o_sync   (w_clk_sync),
        .o_filt   (w_clk_filt),
        .o_fall_c (w_fall)
    );

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_data_line (
        .i_clk    (sys_clk),
        .i_rst_n  (rst_n),
        .i_line   (data),
        .o_sync   (w_data),
        .o_filt   (w_data_filt),
        .o_fall_c (w_data_fall)
    );

    // Data is sampled on the synchronised line; its filtered view is not needed.
    assign w_unused = &{1'b0, w_clk_sync, w_clk_filt, w_data_filt, w_data_fall};

    logic [1:0]           r_state,   w_state_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                 r_parity,  w_parity_nxt;
    logic [WD_W-1:0]      r_wdog,    w_wdog_nxt;
    logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
    logic                 r_rx_valid, w_rx_valid_nxt;
    logic                 r_par_err,  w_par_err_nxt;
    logic                 r_frm_err,  w_frm_err_nxt;
    logic                 r_busy,     w_busy_nxt;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_wdog     <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_wdog     <= w_wdog_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_par_err  <= w_par_err_nxt;
            r_frm_err  <= w_frm_err_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_wdog_nxt     = '0;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_par_err_nxt  = 1'b0;
        w_frm_err_nxt  = 1'b0;

        if (r_state != S_IDLE && !w_fall) begin
            w_wdog_nxt = r_wdog + WD_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_fall && !w_data) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_nxt   = {w_data, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                    if (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_parity_nxt = w_data;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    if (!w_data) begin
                        w_frm_err_nxt = 1'b1;
                    end else if (r_parity == odd_parity_bit(r_shift)) begin
                        w_rx_data_nxt  = r_shift;
                        w_rx_valid_nxt = 1'b1;
                    end else begin
                        w_par_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Stalled keyboard clock: abandon the partial frame; a same-cycle edge takes priority.
        if (r_state != S_IDLE && !w_fall && r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
            w_wdog_nxt    = '0;
            w_frm_err_nxt = 1'b1;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames are bit-banged and expected pulses are queued
// on a scoreboard that a monitor drains as the receiver reports them.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FILT = 4;
    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 30;

    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    typedef struct {
        int             kind;
        logic [7:0]     d;
    } exp_t;

    logic                 sys_clk = 1'b0;
    logic                 rst_n;
    logic                 keyboard_clk;
    logic                 data;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ps2_rx #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .keyboard_clk (keyboard_clk),
        .data         (data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [7:0] d, input logic par,
                                                       input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [FRAME_BITS-1:0] fr, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            data = fr[i];
            repeat (HALF) @(negedge sys_clk);
            keyboard_clk = 1'b0;
            repeat (HALF) @(negedge sys_clk);
            keyboard_clk = 1'b1;
            if (glitch) begin
                repeat (HALF / 2) @(negedge sys_clk);
                keyboard_clk = 1'b0;
                @(negedge sys_clk);
                keyboard_clk = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [FRAME_BITS-1:0] fr, input bit glitch, input string tag);
        send_bits(fr, FRAME_BITS, glitch);
        data = 1'b1;
        repeat (20) @(negedge sys_clk);
        check({tag, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    // Monitor: every report pulse must match the next queued expectation.
    exp_t mon_e;
    int   mon_kind;
    always @(negedge sys_clk) begin
        if (rx_valid || parity_err || frame_err) begin
            check("one_pulse_only", 32'(rx_valid) + 32'(parity_err) + 32'(frame_err), 32'd1);
            mon_kind = rx_valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'(mon_kind) + 32'd100, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
                check("pulse_rx_data", 32'(rx_data), 32'(mon_e.d));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "bench time limit");
    end

    int  n;
    bit  seen;
    logic [FRAME_BITS-1:0] fr;

    initial begin
        rst_n        = 1'b0;
        keyboard_clk = 1'b1;
        data         = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Good 0xAA frame (four ones, parity 1).
        q.push_back('{K_VALID, 8'hAA});
        send_frame(mk_frame(8'hAA, 1'b1, 1'b1), 1'b0, "good_aa");
        check("good_aa_rx_data", 32'(rx_data), 32'hAA);

        // 0xAA with wrong parity: error reported, data held.
        q.push_back('{K_PERR, 8'hAA});
        send_frame(mk_frame(8'hAA, 1'b0, 1'b1), 1'b0, "perr_aa");
        check("perr_aa_rx_hold", 32'(rx_data), 32'hAA);

        // 0x1C (three ones, parity 0) with bad stop bit, then a good 0x1C.
        q.push_back('{K_FERR, 8'hAA});
        send_frame(mk_frame(8'h1C, 1'b0, 1'b0), 1'b0, "stop_err_1c");
        check("stop_err_rx_hold", 32'(rx_data), 32'hAA);
        q.push_back('{K_VALID, 8'h1C});
        send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 1'b0, "good_1c");
        check("good_1c_rx_data", 32'(rx_data), 32'h1C);

        // Keyboard clock stops after the fifth bit.
        fr = mk_frame(8'h55, 1'b1, 1'b1);
        q.push_back('{K_FERR, 8'h1C});
        send_bits(fr, 4, 1'b0);
        data = fr[4];
        repeat (HALF) @(negedge sys_clk);
        keyboard_clk = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < int'(2 * TMO + 100)) begin
            @(negedge sys_clk);
            n++;
            if (n == int'(HALF)) keyboard_clk = 1'b1;
            if (n == 10) check("busy_mid_frame", 32'(busy), 32'd1);
            if (frame_err) seen = 1'b1;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_latency", 32'(n), 32'(SYNC + FILT + 1 + TMO));
        check("busy_after_timeout", 32'(busy), 32'd0);
        data = 1'b1;
        repeat (20) @(negedge sys_clk);
        q.push_back('{K_VALID, 8'h55});
        send_frame(mk_frame(8'h55, 1'b1, 1'b1), 1'b0, "after_timeout_55");
        check("after_timeout_rx_data", 32'(rx_data), 32'h55);

        // Single-cycle low glitches between bits must not add bits.
        q.push_back('{K_VALID, 8'hAA});
        send_frame(mk_frame(8'hAA, 1'b1, 1'b1), 1'b1, "glitch_aa");
        check("glitch_aa_rx_data", 32'(rx_data), 32'hAA);

        // Reset in the middle of a frame.
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 4, 1'b0);
        data  = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_pulses", {29'd0, rx_valid, parity_err, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        q.push_back('{K_VALID, 8'hF0});
        send_frame(mk_frame(8'hF0, 1'b1, 1'b1), 1'b0, "after_reset_f0");
        check("after_reset_rx_data", 32'(rx_data), 32'hF0);

        repeat (10) @(negedge sys_clk);
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
